dmem_arbiter: RTL

Two-requester arbiter for the single-port data memory of the multicycle CPU. It shares the memory between the CPU datapath (ALUOut address, B-register write data) and a debug/loader port. The arbiter grants one requester per cycle, using round-robin priority and a bounded burst length. It also tells the CPU controller to stall whenever a CPU access has not been granted.

---
 rtl/dmem_arb_pkg.sv | 20 ++
 rtl/arb_burst_counter.sv | 40 ++++
 rtl/dmem_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   arb_state_e : FSM encoding (IDLE / GNT_CPU / GNT_DBG)
//   OWN_CPU/DBG : encoding of the last_owner bit
//   grant_state : maps an owner bit to its grant state
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      GNT_CPU = 2'b01,
      GNT_DBG = 2'b10
   } arb_state_e;

   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_DBG = 1'b1;

   function automatic arb_state_e grant_state(input logic owner);
      return (owner == OWN_CPU) ? GNT_CPU : GNT_DBG;
   endfunction

endpackage

// File: rtl/arb_burst_counter.sv
// Burst counter: counts consecutive contended grants to the current owner.
//   clk, rst_n : clock, async active-low reset
//   clr_i      : clear to 0 (wins over inc_i)
//   inc_i      : advance by one
//   tc_o       : count has reached MAX_BURST-1
module arb_burst_counter #(
   parameter int unsigned MAX_BURST = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic inc_i,
   output logic tc_o
);

   localparam int unsigned CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   // next count
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == CW'(MAX_BURST - 1));

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data memory (CPU vs debug/loader).
// Round-robin between requesters with a bounded burst under contention.
//   clk, reset              : clock, async active-low reset
//   cpu_* / dbg_* (in)      : req, we, addr, wdata; held until granted
//   cpu_* / dbg_* (out)     : gnt (access this cycle), valid (read data ready),
//                             rdata (registered read data)
//   cpu_stall               : CPU request not granted this cycle
//   mem_addr/wdata/we       : muxed memory access, zero when idle
//   mem_rdata               : combinational memory read data
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned MAX_BURST  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic                  cpu_gnt,
   output logic                  cpu_valid,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_stall,
   input  logic                  dbg_req,
   input  logic                  dbg_we,
   input  logic [ADDR_WIDTH-1:0] dbg_addr,
   input  logic [DATA_WIDTH-1:0] dbg_wdata,
   output logic                  dbg_gnt,
   output logic                  dbg_valid,
   output logic [DATA_WIDTH-1:0] dbg_rdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_we,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   arb_state_e state_q, state_d;
   logic       last_q, last_d;
   logic       cnt_clr, cnt_inc, cnt_tc;

   logic                  cpu_valid_q, dbg_valid_q;
   logic [DATA_WIDTH-1:0] cpu_rdata_q, dbg_rdata_q;

   arb_burst_counter #(
      .MAX_BURST (MAX_BURST)
   ) u_burst_cnt (
      .clk   (clk),
      .rst_n (reset),
      .clr_i (cnt_clr),
      .inc_i (cnt_inc),
      .tc_o  (cnt_tc)
   );

   // state and last_owner registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         last_q  <= OWN_DBG;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

   // next state, last_owner and burst-counter control
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      cnt_inc = 1'b0;
      cnt_clr = 1'b1;
      unique case (state_q)
         IDLE: begin
            if (cpu_req && dbg_req) begin
               state_d = grant_state(~last_q);
            end else if (cpu_req) begin
               state_d = GNT_CPU;
            end else if (dbg_req) begin
               state_d = GNT_DBG;
            end
         end
         GNT_CPU: begin
            if (!cpu_req) begin
               state_d = dbg_req ? GNT_DBG : IDLE;
            end else if (dbg_req && cnt_tc) begin
               state_d = GNT_DBG;
            end
            // count only while keeping ownership against a waiting rival
            cnt_inc = (state_d == GNT_CPU) && dbg_req;
         end
         GNT_DBG: begin
            if (!dbg_req) begin
               state_d = cpu_req ? GNT_CPU : IDLE;
            end else if (cpu_req && cnt_tc) begin
               state_d = GNT_CPU;
            end
            cnt_inc = (state_d == GNT_DBG) && cpu_req;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      cnt_clr = ~cnt_inc;
      if (state_d == GNT_CPU) begin
         last_d = OWN_CPU;
      end else if (state_d == GNT_DBG) begin
         last_d = OWN_DBG;
      end
   end

   // grant and memory mux; combinational from state so reset drops them at once
   always_comb begin
      cpu_gnt   = 1'b0;
      dbg_gnt   = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      unique case (state_q)
         GNT_CPU: begin
            cpu_gnt   = cpu_req;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we    = cpu_req & cpu_we;
         end
         GNT_DBG: begin
            dbg_gnt   = dbg_req;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            mem_we    = dbg_req & dbg_we;
         end
         default: ;
      endcase
   end

   // read-data capture; rdata holds until the owner's next granted read
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cpu_valid_q <= 1'b0;
         dbg_valid_q <= 1'b0;
         cpu_rdata_q <= '0;
         dbg_rdata_q <= '0;
      end else begin
         cpu_valid_q <= cpu_gnt & ~cpu_we;
         dbg_valid_q <= dbg_gnt & ~dbg_we;
         if (cpu_gnt && !cpu_we) begin
            cpu_rdata_q <= mem_rdata;
         end
         if (dbg_gnt && !dbg_we) begin
            dbg_rdata_q <= mem_rdata;
         end
      end
   end

   assign cpu_valid = cpu_valid_q;
   assign dbg_valid = dbg_valid_q;
   assign cpu_rdata = cpu_rdata_q;
   assign dbg_rdata = dbg_rdata_q;
   assign cpu_stall = cpu_req & ~cpu_gnt;

endmodule
